// File: rtl/bubble_sequencer.sv
// Purpose: sequences one bubble-memory page access (seek, replicate, read, stop) against TimingGenerator position steps.
// Latency: every output is registered and changes one master_clock after the step/start/coil event that causes it.
// Backpressure: none; start is accepted only in IDLE and dropped while busy, no request is queued.
//
// Ports:
//   master_clock         system clock, all logic on its rising edge
//   reset                asynchronous active-high reset
//   start                access request pulse, sampled only in IDLE
//   target_position      loop position at which replication begins
//   bootloop_select      1 = bootloop/program page, 0 = data page
//   position_change      TimingGenerator position notification (multi-cycle, active high)
//   coil_enable          TimingGenerator COIL RUN, active low
//   bubble_shift_enable  shift request, active low
//   replicator_enable    replicator request, active low
//   bootloop_enable      bootloop page request, active high
//   busy                 high in any state other than IDLE
//   done                 one-cycle pulse at the end of an access
//   error                qualified by done; target was out of range
//   bit_strobe           one-cycle pulse per read bit position
//   bit_index            index of the bit carried by bit_strobe
//   current_position     tracked loop position
module bubble_sequencer #(
    parameter int POSITIONS = 2053,
    parameter int PAGE_BITS = 584
) (
    input  logic        master_clock,
    input  logic        reset,
    input  logic        start,
    input  logic [11:0] target_position,
    input  logic        bootloop_select,
    input  logic        position_change,
    input  logic        coil_enable,
    output logic        bubble_shift_enable,
    output logic        replicator_enable,
    output logic        bootloop_enable,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        bit_strobe,
    output logic [9:0]  bit_index,
    output logic [11:0] current_position
);

    localparam logic [11:0] LAST_POSITION  = 12'(POSITIONS - 1);
    localparam logic [12:0] POSITION_LIMIT = 13'(POSITIONS);
    localparam logic [9:0]  LAST_BIT       = 10'(PAGE_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        SEEK,
        REPLICATE,
        READ,
        STOP,
        DONE
    } state_t;

    state_t      state;
    logic        position_change_q;
    logic        step;
    logic        target_valid;
    logic [11:0] next_position;
    logic [11:0] target_q;
    logic [9:0]  read_count;
    logic        error_q;

    // A notification is a single step no matter how many cycles it stays high.
    assign step          = position_change & ~position_change_q;
    assign next_position = (current_position == LAST_POSITION) ? 12'd0 : current_position + 12'd1;
    assign target_valid  = ({1'b0, target_position} < POSITION_LIMIT);

    // Loop position follows the bubbles only while the shift request is active.
    always_ff @(posedge master_clock or posedge reset) begin
        if (reset) begin
            position_change_q <= 1'b0;
            current_position  <= 12'd0;
        end else begin
            position_change_q <= position_change;
            if (step && !bubble_shift_enable) begin
                current_position <= next_position;
            end
        end
    end

    always_ff @(posedge master_clock or posedge reset) begin
        if (reset) begin
            state               <= IDLE;
            bubble_shift_enable <= 1'b1;
            replicator_enable   <= 1'b1;
            bootloop_enable     <= 1'b0;
            busy                <= 1'b0;
            done                <= 1'b0;
            error               <= 1'b0;
            bit_strobe          <= 1'b0;
            bit_index           <= 10'd0;
            target_q            <= 12'd0;
            read_count          <= 10'd0;
            error_q             <= 1'b0;
        end else begin
            done       <= 1'b0;
            error      <= 1'b0;
            bit_strobe <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        target_q <= target_position;
                        if (target_valid) begin
                            state               <= SEEK;
                            bubble_shift_enable <= 1'b0;
                            bootloop_enable     <= bootloop_select;
                            error_q             <= 1'b0;
                        end else begin
                            // Out-of-range target: report without ever shifting.
                            state   <= DONE;
                            error_q <= 1'b1;
                        end
                    end
                end
                SEEK: begin
                    // Compare against the post-step position, so a target equal to the
                    // entry position costs a full revolution.
                    if (step && (next_position == target_q)) begin
                        state             <= REPLICATE;
                        replicator_enable <= 1'b0;
                    end
                end
                REPLICATE: begin
                    if (step) begin
                        state             <= READ;
                        replicator_enable <= 1'b1;
                        bit_index         <= 10'd0;
                        read_count        <= 10'd0;
                    end
                end
                READ: begin
                    if (step) begin
                        // bit_index is loaded alongside the strobe so both present the same bit.
                        bit_strobe <= 1'b1;
                        bit_index  <= read_count;
                        read_count <= read_count + 10'd1;
                        if (read_count == LAST_BIT) begin
                            state               <= STOP;
                            bubble_shift_enable <= 1'b1;
                            replicator_enable   <= 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (coil_enable) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    done            <= 1'b1;
                    error           <= error_q;
                    bootloop_enable <= 1'b0;
                    busy            <= 1'b0;
                    state           <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bubble_sequencer.sv
module tb_bubble_sequencer;

    localparam int P      = 16;
    localparam int B      = 4;
    localparam int PERIOD = 40;

    logic        master_clock;
    logic        reset;
    logic        start;
    logic [11:0] target_position;
    logic        bootloop_select;
    logic        position_change;
    logic        coil_enable;
    logic        bubble_shift_enable;
    logic        replicator_enable;
    logic        bootloop_enable;
    logic        busy;
    logic        done;
    logic        error;
    logic        bit_strobe;
    logic [9:0]  bit_index;
    logic [11:0] current_position;

    bubble_sequencer #(.POSITIONS(P), .PAGE_BITS(B)) dut (
        .master_clock        (master_clock),
        .reset               (reset),
        .start               (start),
        .target_position     (target_position),
        .bootloop_select     (bootloop_select),
        .position_change     (position_change),
        .coil_enable         (coil_enable),
        .bubble_shift_enable (bubble_shift_enable),
        .replicator_enable   (replicator_enable),
        .bootloop_enable     (bootloop_enable),
        .busy                (busy),
        .done                (done),
        .error               (error),
        .bit_strobe          (bit_strobe),
        .bit_index           (bit_index),
        .current_position    (current_position)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Environment and observation state
    int         phase;
    logic [3:0] coil_hist;
    bit         in_seek;
    bit         mon_pc;
    logic       exp_boot;
    int         seek_steps;
    int         rep_low;
    int         done_total;
    int         rule_viol;
    int         boot_viol;
    int         wraps;
    logic [11:0] prev_cp;
    logic [9:0] strobe_q[$];

    // Reference model: loop position and expected done count
    int pos_model;
    int exp_done;

    initial begin
        master_clock = 1'b0;
        forever #5 master_clock = ~master_clock;
    end

    // TimingGenerator position notifications: 4-cycle pulses every 40 cycles.
    initial begin
        phase = 0;
        position_change = 1'b0;
        forever begin
            @(negedge master_clock);
            phase = (phase + 1) % PERIOD;
            position_change = (phase < 4);
        end
    end

    // TimingGenerator coil: stops (goes high) four cycles after shifting is released.
    initial begin
        coil_hist = 4'hF;
        coil_enable = 1'b1;
        forever begin
            @(negedge master_clock);
            coil_hist = {coil_hist[2:0], bubble_shift_enable};
            coil_enable = coil_hist[3];
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Observer sampling just after each rising edge.
    initial begin
        bit step_now;
        in_seek = 0; mon_pc = 0; exp_boot = 1'b0;
        seek_steps = 0; rep_low = 0; done_total = 0;
        rule_viol = 0; boot_viol = 0; wraps = 0; prev_cp = 12'd0;
        forever begin
            @(posedge master_clock);
            #1;
            if (reset) begin
                mon_pc = 0;
                step_now = 0;
            end else begin
                step_now = position_change && !mon_pc;
                mon_pc = position_change;
            end
            if (in_seek && step_now) seek_steps++;
            if (in_seek && !replicator_enable) in_seek = 0;
            if (!replicator_enable) rep_low++;
            if (bit_strobe) strobe_q.push_back(bit_index);
            if (done) done_total++;
            if (!replicator_enable && bubble_shift_enable) rule_viol++;
            if (busy && (bootloop_enable !== exp_boot)) boot_viol++;
            if (prev_cp == 12'd15 && current_position == 12'd0) wraps++;
            prev_cp = current_position;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string ctx);
        check({ctx, "_shift"},    32'(bubble_shift_enable), 1);
        check({ctx, "_repl"},     32'(replicator_enable), 1);
        check({ctx, "_boot"},     32'(bootloop_enable), 0);
        check({ctx, "_busy"},     32'(busy), 0);
        check({ctx, "_done"},     32'(done), 0);
        check({ctx, "_error"},    32'(error), 0);
        check({ctx, "_strobe"},   32'(bit_strobe), 0);
        check({ctx, "_index"},    32'(bit_index), 0);
        check({ctx, "_position"}, 32'(current_position), 0);
    endtask

    // Issue a start away from any notification edge and check the first response.
    task automatic launch(input int tgt, input bit sel);
        int p = $urandom_range(35, 6);
        for (int i = 0; i < 2 * PERIOD; i++) begin
            @(posedge master_clock);
            #2;
            if (phase == p) break;
        end
        @(negedge master_clock);
        start = 1'b1;
        target_position = 12'(tgt);
        bootloop_select = sel;
        seek_steps = 0;
        rep_low = 0;
        strobe_q.delete();
        in_seek = (tgt < P);
        exp_boot = (tgt < P) ? sel : 1'b0;
        @(posedge master_clock);
        #1;
        check("busy_after_start", 32'(busy), 1);
        check("shift_after_start", 32'(bubble_shift_enable), (tgt < P) ? 0 : 1);
        @(negedge master_clock);
        start = 1'b0;
    endtask

    task automatic do_access(input int tgt, input bit sel, input bit inject);
        bit valid = (tgt < P);
        int d = (((tgt - pos_model) % P) + P) % P;
        int cyc = 1;
        bit got = 0;
        bit injected = 0;
        if (d == 0) d = P;
        launch(tgt, sel);
        for (int i = 0; i < 3000; i++) begin
            @(posedge master_clock);
            #1;
            cyc++;
            if (done) begin
                got = 1;
                break;
            end
            if (inject && !injected && strobe_q.size() == 2) begin
                injected = 1;
                @(negedge master_clock);
                start = 1'b1;
                target_position = 12'($urandom_range(15, 0));
                @(negedge master_clock);
                start = 1'b0;
            end
        end
        check("done_seen", 32'(got), 1);
        if (got) begin
            exp_done++;
            check("error_flag", 32'(error), valid ? 0 : 1);
            check("boot_at_done", 32'(bootloop_enable), 0);
            check("busy_at_done", 32'(busy), 0);
            check("shift_at_done", 32'(bubble_shift_enable), 1);
            if (!valid) begin
                check("error_latency", 32'(cyc), 2);
                check("error_no_strobes", 32'(strobe_q.size()), 0);
            end else begin
                check("seek_steps", 32'(seek_steps), 32'(d));
                check("replicate_cycles", 32'(rep_low), 32'(PERIOD));
                check("strobe_count", 32'(strobe_q.size()), 32'(B));
                if (strobe_q.size() == B) begin
                    for (int k = 0; k < B; k++) check("strobe_index", 32'(strobe_q[k]), 32'(k));
                end
                pos_model = (tgt + 1 + B) % P;
                check("final_position", 32'(current_position), 32'(pos_model));
            end
            @(posedge master_clock);
            #1;
            check("done_one_cycle", 32'(done), 0);
            check("done_total", 32'(done_total), 32'(exp_done));
        end
    endtask

    initial begin
        int w0;
        int done_before;
        bit got;
        reset = 1'b1;
        start = 1'b0;
        target_position = 12'd0;
        bootloop_select = 1'b0;
        pos_model = 0;
        exp_done = 0;
        repeat (3) @(negedge master_clock);
        check_reset_values("reset");
        reset = 1'b0;
        repeat (5) @(negedge master_clock);

        // Basic access from position 0 to target 3
        do_access(3, 1'b0, 1'b0);

        // Reset while replicating abandons the access
        launch(5, 1'b1);
        got = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge master_clock);
            #1;
            if (!replicator_enable) begin
                got = 1;
                break;
            end
        end
        check("reached_replicate", 32'(got), 1);
        #2 reset = 1'b1;
        #1;
        check_reset_values("mid_access");
        in_seek = 0;
        done_before = done_total;
        repeat (3) @(negedge master_clock);
        reset = 1'b0;
        pos_model = 0;
        repeat (60) @(posedge master_clock);
        #1;
        check("no_done_after_abort", 32'(done_total), 32'(done_before));

        // Target equal to current position: full revolution with wrap
        w0 = wraps;
        do_access(0, 1'b0, 1'b0);
        check("wrap_15_to_0", 32'(wraps - w0), 1);

        // Normal access after the aborted one
        do_access(2, 1'b0, 1'b0);

        // Out-of-range target
        do_access(20, 1'b0, 1'b0);

        // Bootloop page with a stray start during READ
        do_access(int'($urandom_range(15, 0)), 1'b1, 1'b1);

        // Randomized accesses
        for (int r = 0; r < 6; r++) begin
            do_access(int'($urandom_range(19, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
        end

        repeat (10) @(posedge master_clock);
        #1;
        check("replicator_only_while_shifting", 32'(rule_viol), 0);
        check("bootloop_while_busy", 32'(boot_viol), 0);
        check("total_done_pulses", 32'(done_total), 32'(exp_done));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
